// File: rtl/ad_data_fifo_sync.sv
// ---------------------------------------------------------------------------
// ad_data_fifo_sync
//
// Single-clock data buffer between the AD sample packer and the HSST framer.
// It absorbs framer back-pressure and reports a combined occupancy count,
// registered almost-full/almost-empty flags and sticky overflow/underflow
// error flags with a software clear.
//
// Build option:
//   AD_DATA_FIFO_SYNC_FWFT_EN  defined   -> first-word-fall-through read mode:
//                                           rd_data shows the head word
//                                           whenever rd_empty=0; rd_en pops it.
//                              undefined -> standard mode: rd_data updates one
//                                           cycle after an accepted read.
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous, active-high reset
//   wr_data/wr_en write word and write request
//   wr_full       level == 2**DEPTH_WIDTH
//   almost_full   level >= ALMOST_FULL_NUM
//   rd_en         read request (pop)
//   rd_data       read word
//   rd_empty      no readable word
//   almost_empty  level <= ALMOST_EMPTY_NUM
//   water_level   words held, 0..2**DEPTH_WIDTH
//   err_clr       clears the sticky error flags
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
//
// Handshake: wr_en/rd_en are single-cycle requests, not held handshakes.
// A write is accepted when the buffer is not full, or when a read is
// accepted in the same cycle; a read is accepted when rd_empty is low.
// A rejected request is dropped (no state change) and sets its error flag.
// ---------------------------------------------------------------------------
module ad_data_fifo_sync #(
    parameter int DATA_WIDTH       = 8,
    parameter int DEPTH_WIDTH      = 8,
    parameter int ALMOST_FULL_NUM  = 252,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   wr_en,
    output logic                   wr_full,
    output logic                   almost_full,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_empty,
    output logic                   almost_empty,
    output logic [DEPTH_WIDTH:0]   water_level,
    input  logic                   err_clr,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int                 CAP_INT   = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] CAPACITY = (DEPTH_WIDTH+1)'(CAP_INT);
    localparam logic [DEPTH_WIDTH:0] AF_LEVEL = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
    localparam logic [DEPTH_WIDTH:0] AE_LEVEL = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

    logic [DATA_WIDTH-1:0]  mem [0:CAP_INT-1];
    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic                   wr_acc;
    logic                   rd_acc;
    logic [DEPTH_WIDTH:0]   level_next;

    // rd_empty is the single readable-word indication in both modes, so it
    // qualifies the pop. A pop in the same cycle frees the slot a write
    // needs, which is what lets a full buffer stream at one word per cycle.
    assign rd_acc     = rd_en && !rd_empty;
    assign wr_acc     = wr_en && (!wr_full || rd_acc);
    assign level_next = water_level + (DEPTH_WIDTH+1)'(wr_acc)
                                    - (DEPTH_WIDTH+1)'(rd_acc);

    // Occupancy, level flags, write pointer and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            water_level  <= '0;
            wr_full      <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + DEPTH_WIDTH'(1);
            end
            water_level  <= level_next;
            wr_full      <= (level_next == CAPACITY);
            almost_full  <= (level_next >= AF_LEVEL);
            almost_empty <= (level_next <= AE_LEVEL);
            // A set event wins over a clear in the same cycle.
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && !rd_acc) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    // Storage carries no reset; zeroing the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

`ifdef AD_DATA_FIFO_SYNC_FWFT_EN
    // rd_data doubles as the prefetch register; rd_empty is its inverted
    // valid bit. ram_cnt counts words still in the RAM (level minus the one
    // held in rd_data). A fetch happens whenever the register is empty or
    // being popped and the RAM has a word; a word written at edge N is
    // therefore fetched at edge N+1 at the earliest.
    logic [DEPTH_WIDTH:0] ram_cnt;
    logic                 ram_rd;

    assign ram_rd = (ram_cnt != '0) && (rd_empty || rd_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_empty <= 1'b1;
            ram_cnt  <= '0;
        end else begin
            if (ram_rd) begin
                rd_ptr  <= rd_ptr + DEPTH_WIDTH'(1);
                rd_data <= mem[rd_ptr];
            end
            rd_empty <= !(ram_rd || (!rd_empty && !rd_acc));
            ram_cnt  <= ram_cnt + (DEPTH_WIDTH+1)'(wr_acc)
                                - (DEPTH_WIDTH+1)'(ram_rd);
        end
    end
`else
    // Standard mode: rd_data is loaded on an accepted read and then holds.
    // At full with a simultaneous write, wr_ptr == rd_ptr; the read samples
    // the old word because both updates are non-blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_empty <= 1'b1;
        end else begin
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + DEPTH_WIDTH'(1);
                rd_data <= mem[rd_ptr];
            end
            rd_empty <= (level_next == '0);
        end
    end
`endif

endmodule

// File: tb/tb_ad_data_fifo_sync.sv
// ---------------------------------------------------------------------------
// tb_ad_data_fifo_sync
//
// Bench for ad_data_fifo_sync in either read mode (AD_DATA_FIFO_SYNC_FWFT_EN).
// The reference is a queue of stored words, each tagged with the clock edge
// that wrote it; occupancy, flags and read data follow from the queue.
// In first-word-fall-through mode the head word is readable after edge e
// once it was written at an edge before e.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ad_data_fifo_sync;

    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int CAP = 256;
    localparam int AF  = 252;
    localparam int AE  = 4;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic tb_rst = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          wr_full;
    logic          almost_full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_empty;
    logic          almost_empty;
    logic [AW:0]   water_level;
    logic          err_clr;
    logic          overflow;
    logic          underflow;

    ad_data_fifo_sync #(
        .DATA_WIDTH       (DW),
        .DEPTH_WIDTH      (AW),
        .ALMOST_FULL_NUM  (AF),
        .ALMOST_EMPTY_NUM (AE)
    ) dut (
        .clk          (clk),
        .rst          (tb_rst),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .wr_full      (wr_full),
        .almost_full  (almost_full),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_empty     (rd_empty),
        .almost_empty (almost_empty),
        .water_level  (water_level),
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // ---------------- scoreboard / reference model ----------------
    logic [DW-1:0] exp_q[$];
    int            stamp_q[$];
    int            edge_n = 0;
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
    logic [DW-1:0] m_rd_data = '0;
    bit            m_rd_acc;
    bit            m_wr_acc;
    bit            m_vis;
    bit            chk_en = 1'b0;
    int            total = 0;
    int            bad = 0;

    // Is the head word readable in the interval after edge e?
    function automatic bit head_visible(input int e);
`ifdef AD_DATA_FIFO_SYNC_FWFT_EN
        return (exp_q.size() > 0) && (stamp_q[0] < e);
`else
        return (exp_q.size() > 0) && (e >= 0);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model advances on every rising edge using the inputs held since the
    // preceding falling edge.
    always @(posedge clk) begin
        edge_n++;
        if (tb_rst) begin
            exp_q.delete();
            stamp_q.delete();
            m_ovf     = 1'b0;
            m_unf     = 1'b0;
            m_rd_data = '0;
        end else begin
            m_rd_acc = rd_en && head_visible(edge_n - 1);
            m_wr_acc = wr_en && ((exp_q.size() < CAP) || m_rd_acc);
            if (m_rd_acc) begin
                m_rd_data = exp_q.pop_front();
                void'(stamp_q.pop_front());
            end
            if (m_wr_acc) begin
                exp_q.push_back(wr_data);
                stamp_q.push_back(edge_n);
            end
            if (wr_en && !m_wr_acc) m_ovf = 1'b1;
            else if (err_clr)       m_ovf = 1'b0;
            if (rd_en && !m_rd_acc) m_unf = 1'b1;
            else if (err_clr)       m_unf = 1'b0;
        end
    end

    // Compare every output against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            m_vis = head_visible(edge_n);
            chk("water_level",  32'(water_level),  32'(exp_q.size()));
            chk("wr_full",      32'(wr_full),      32'(exp_q.size() == CAP));
            chk("almost_full",  32'(almost_full),  32'(exp_q.size() >= AF));
            chk("almost_empty", 32'(almost_empty), 32'(exp_q.size() <= AE));
            chk("rd_empty",     32'(rd_empty),     32'(!m_vis));
            chk("overflow",     32'(overflow),     32'(m_ovf));
            chk("underflow",    32'(underflow),    32'(m_unf));
`ifdef AD_DATA_FIFO_SYNC_FWFT_EN
            if (m_vis) chk("rd_data", 32'(rd_data), 32'(exp_q[0]));
`else
            chk("rd_data", 32'(rd_data), 32'(m_rd_data));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        err_clr = c;
        @(negedge clk);
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic do_reset();
        tb_rst = 1'b1;
        @(negedge clk);
        tb_rst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_level"},    32'(water_level),  32'd0);
        chk({tag, "_full"},     32'(wr_full),      32'd0);
        chk({tag, "_afull"},    32'(almost_full),  32'd0);
        chk({tag, "_empty"},    32'(rd_empty),     32'd1);
        chk({tag, "_aempty"},   32'(almost_empty), 32'd1);
        chk({tag, "_ovf"},      32'(overflow),     32'd0);
        chk({tag, "_unf"},      32'(underflow),    32'd0);
        chk({tag, "_rd_data"},  32'(rd_data),      32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        wr_data = '0;
        tb_rst  = 1'b1;
        repeat (2) @(negedge clk);
        tb_rst = 1'b0;
        chk_en = 1'b1;
        check_reset_values("reset");

        // Fill with 255 down to 0.
        for (int i = 0; i < CAP; i++) begin
            drive(1'b1, DW'(255 - i), 1'b0, 1'b0);
            chk("fill_afull", 32'(almost_full), 32'((i + 1) >= 252));
        end
        chk("fill_full",  32'(wr_full),     32'd1);
        chk("fill_level", 32'(water_level), 32'd256);
        chk("fill_ovf",   32'(overflow),    32'd0);

        // One write too many, then clear.
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_set",   32'(overflow),    32'd1);
        chk("ovf_level", 32'(water_level), 32'd256);
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_clr",   32'(overflow),    32'd0);

        // Drain: 255..0, and 0xAA must not appear.
        for (int i = 0; i < CAP; i++) begin
`ifdef AD_DATA_FIFO_SYNC_FWFT_EN
            chk("drain_data", 32'(rd_data), 32'(255 - i));
            drive(1'b0, '0, 1'b1, 1'b0);
`else
            drive(1'b0, '0, 1'b1, 1'b0);
            chk("drain_data", 32'(rd_data), 32'(255 - i));
`endif
        end
        chk("drain_empty",  32'(rd_empty),     32'd1);
        chk("drain_aempty", 32'(almost_empty), 32'd1);
        chk("drain_level",  32'(water_level),  32'd0);

        // Underflow: set, set wins over clear, then clear.
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("unf_set",     32'(underflow), 32'd1);
        chk("unf_rd_data", 32'(rd_data),   32'd0);
        drive(1'b0, '0, 1'b1, 1'b1);
        chk("unf_prio",    32'(underflow), 32'd1);
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("unf_clr",     32'(underflow), 32'd0);

        // Stream at full, then at level 100 (crosses pointer wrap often).
        for (int i = 0; i < CAP; i++) drive(1'b1, DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) drive(1'b1, DW'($urandom), 1'b1, 1'b0);
        chk("stream_full_level", 32'(water_level), 32'd256);
        chk("stream_full_ovf",   32'(overflow),    32'd0);
        for (int i = 0; i < 156; i++) drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) drive(1'b1, DW'($urandom), 1'b1, 1'b0);
        chk("stream_100_level", 32'(water_level), 32'd100);

        // Random traffic with varying bias to visit full and empty.
        for (int seg = 0; seg < 6; seg++) begin
            int wb;
            int rb;
            wb = (seg % 2 == 0) ? 80 : 25;
            rb = (seg % 2 == 0) ? 30 : 85;
            for (int i = 0; i < 400; i++) begin
                drive($urandom_range(0, 99) < wb, DW'($urandom),
                      $urandom_range(0, 99) < rb, $urandom_range(0, 99) < 3);
            end
        end

        // Bring level to 50, then reset mid-operation.
        for (int k = 0; k < 600 && exp_q.size() != 50; k++) begin
            drive(exp_q.size() < 50, DW'($urandom), exp_q.size() > 50, 1'b0);
        end
        chk("lvl50", 32'(water_level), 32'd50);
        do_reset();
        check_reset_values("midrst");

        // Single word after reset.
        drive(1'b1, 8'h5C, 1'b0, 1'b0);
`ifdef AD_DATA_FIFO_SYNC_FWFT_EN
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("post_rst_empty", 32'(rd_empty), 32'd0);
        chk("post_rst_data",  32'(rd_data),  32'h5C);
        drive(1'b0, '0, 1'b1, 1'b0);
`else
        chk("post_rst_empty", 32'(rd_empty), 32'd0);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("post_rst_data",  32'(rd_data),  32'h5C);
`endif
        chk("post_rst_level", 32'(water_level), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
